// File: rtl/alu_seq_bcd.sv
// Multi-cycle unsigned ALU (ADD/SUB/MUL/DIV) with sequential double-dabble BCD output
// and valid/ready handshakes. Define ALU_REM_EN to add the DIV remainder port.
module alu_seq_bcd #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in1,
    input  logic [WIDTH-1:0]      in2,
    input  logic [1:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*WIDTH-1:0]    result,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  zero,
    output logic                  error
`ifdef ALU_REM_EN
    ,
    output logic [WIDTH-1:0]      remainder
`endif
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(RW);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Enough BCD digits to represent the largest RW-bit result.
    if (pow10(DIGITS) <= ((64'(1) << RW) - 64'(1))) begin : g_digits_chk
        $error("alu_seq_bcd: DIGITS too small for result width");
    end

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_e;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [RW-1:0]     a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [RW-1:0]     sh_q, sh_d;
    logic [BW-1:0]     dig_q, dig_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [RW-1:0]     result_q, result_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              zero_q, zero_d;
    logic              error_q, error_d;
`ifdef ALU_REM_EN
    logic [WIDTH-1:0]  remo_q, remo_d;
`endif

    logic              err_c;
    logic              qbit_c;
    logic [WIDTH:0]    rem_sh_c;
    logic [BW-1:0]     adj_c;

    // Next-state, datapath iteration and registered-output updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        sh_d        = sh_q;
        dig_d       = dig_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        bcd_d       = bcd_q;
        zero_d      = zero_q;
        error_d     = error_q;
`ifdef ALU_REM_EN
        remo_d      = remo_q;
`endif
        err_c       = 1'b0;
        qbit_c      = 1'b0;
        rem_sh_c    = '0;
        adj_c       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d       = op_e'(op);
                    a_d        = RW'(in1);
                    b_d        = in2;
                    acc_d      = '0;
                    rem_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + CW'(1);
                unique case (op_q)
                    OP_ADD: begin
                        acc_d   = a_q + RW'(b_q);
                        state_d = S_CONV;
                    end
                    OP_SUB: begin
                        if (a_q < RW'(b_q)) begin
                            err_c = 1'b1;
                        end else begin
                            acc_d   = a_q - RW'(b_q);
                            state_d = S_CONV;
                        end
                    end
                    OP_MUL: begin
                        if (b_q[0]) acc_d = acc_q + a_q;
                        a_d = a_q << 1;
                        b_d = b_q >> 1;
                        if (cnt_q == CW'(WIDTH - 1)) state_d = S_CONV;
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            err_c = 1'b1;
                        end else begin
                            // Restoring step: bring in next dividend bit, subtract if it fits.
                            rem_sh_c = {rem_q, a_q[WIDTH-1]};
                            if (rem_sh_c >= {1'b0, b_q}) begin
                                rem_d  = WIDTH'(rem_sh_c - {1'b0, b_q});
                                qbit_c = 1'b1;
                            end else begin
                                rem_d  = WIDTH'(rem_sh_c);
                            end
                            acc_d = {acc_q[RW-2:0], qbit_c};
                            a_d   = a_q << 1;
                            if (cnt_q == CW'(WIDTH - 1)) state_d = S_CONV;
                        end
                    end
                endcase
                if (err_c) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    bcd_d       = '1;
                    zero_d      = 1'b0;
                    error_d     = 1'b1;
`ifdef ALU_REM_EN
                    remo_d      = '0;
`endif
                end else if (state_d == S_CONV) begin
                    sh_d  = acc_d;
                    dig_d = '0;
                    cnt_d = '0;
                end
            end
            S_CONV: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    adj_c[4*i +: 4] = (dig_q[4*i +: 4] >= 4'd5) ? dig_q[4*i +: 4] + 4'd3
                                                                : dig_q[4*i +: 4];
                end
                dig_d = {adj_c[BW-2:0], sh_q[RW-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(RW - 1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    result_d    = acc_q;
                    bcd_d       = {adj_c[BW-2:0], sh_q[RW-1]};
                    zero_d      = (acc_q == '0);
                    error_d     = 1'b0;
`ifdef ALU_REM_EN
                    remo_d      = (op_q == OP_DIV) ? rem_q : '0;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            sh_q        <= '0;
            dig_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            bcd_q       <= '0;
            zero_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef ALU_REM_EN
            remo_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            sh_q        <= sh_d;
            dig_q       <= dig_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            bcd_q       <= bcd_d;
            zero_q      <= zero_d;
            error_q     <= error_d;
`ifdef ALU_REM_EN
            remo_q      <= remo_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign bcd       = bcd_q;
    assign zero      = zero_q;
    assign error     = error_q;
`ifdef ALU_REM_EN
    assign remainder = remo_q;
`endif

endmodule
